// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes, FSM states,
// the divide-by-zero LO value and the stall/divider handshake levels.
package md_ctrl_pkg;

  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    MD_IDLE     = 3'd0,
    MD_MUL_WAIT = 3'd1,
    MD_DIV_RUN  = 3'd2,
    MD_DONE     = 3'd3,
    MD_HOLD     = 3'd4
  } md_state_e;

  localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFF_FFFF;

  localparam logic STOP             = 1'b1;
  localparam logic NO_STOP          = 1'b0;
  localparam logic DIV_START        = 1'b1;
  localparam logic DIV_STOP         = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;

endpackage

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: latches one EX mul/div op, stalls until the
// external multiplier or divider produces a result, then writes HI/LO once.
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  input  logic [1:0]          op_code,
  input  logic [DATA_W-1:0]   op_a,
  input  logic [DATA_W-1:0]   op_b,
  input  logic                ex_hold,
  input  logic                flush,
  output logic                stallreq,
  output logic                busy,
  output logic                mul_signed,
  output logic [DATA_W-1:0]   mul_ina,
  output logic [DATA_W-1:0]   mul_inb,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                div_start,
  output logic                div_annul,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_opdata1,
  output logic [DATA_W-1:0]   div_opdata2,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_ready,
  output logic                hi_we,
  output logic                lo_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic [DATA_W-1:0]   lo_wdata
);

  localparam logic [2:0]        CNT_INIT   = 3'(MUL_LAT - 1);
  // Sign-extending the all-ones constant keeps it all-ones for any DATA_W.
  localparam logic [DATA_W-1:0] DIVZERO_LO = DATA_W'($signed(MD_DIVZERO_LO));

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [1:0]        opc_q, opc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    stallreq    = NO_STOP;
    mul_signed  = 1'b0;
    mul_ina     = '0;
    mul_inb     = '0;
    div_start   = DIV_STOP;
    div_annul   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = '0;
    div_opdata2 = '0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (op_valid && !flush) begin
          stallreq = STOP;
          opa_d    = op_a;
          opb_d    = op_b;
          opc_d    = op_code;
          case (op_code)
            MD_OP_MULT, MD_OP_MULTU: begin
              state_d = MD_MUL_WAIT;
              cnt_d   = CNT_INIT;
            end
            MD_OP_DIV, MD_OP_DIVU: begin
              // Divide by zero never reaches the divider.
              if (op_b == '0) begin
                hi_d    = op_a;
                lo_d    = DIVZERO_LO;
                state_d = MD_DONE;
              end else begin
                state_d = MD_DIV_RUN;
              end
            end
          endcase
        end
      end
      MD_MUL_WAIT: begin
        stallreq   = STOP;
        mul_signed = (opc_q == MD_OP_MULT);
        mul_ina    = opa_q;
        mul_inb    = opb_q;
        if (cnt_q == '0) begin
          hi_d    = mul_result[2*DATA_W-1:DATA_W];
          lo_d    = mul_result[DATA_W-1:0];
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      MD_DIV_RUN: begin
        stallreq    = STOP;
        div_signed  = (opc_q == MD_OP_DIV);
        div_opdata1 = opa_q;
        div_opdata2 = opb_q;
        if (div_ready == DIV_RESULT_READY) begin
          hi_d    = div_result[2*DATA_W-1:DATA_W];
          lo_d    = div_result[DATA_W-1:0];
          state_d = MD_DONE;
        end else begin
          div_start = DIV_START;
        end
      end
      MD_DONE: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        state_d = ex_hold ? MD_HOLD : MD_IDLE;
      end
      MD_HOLD: begin
        // Same instruction still parked in EX: wait it out without re-issuing.
        if (!ex_hold) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase

    if (flush) begin
      state_d   = MD_IDLE;
      stallreq  = NO_STOP;
      div_start = DIV_STOP;
      div_annul = (state_q == MD_DIV_RUN);
      hi_we     = 1'b0;
      lo_we     = 1'b0;
    end
  end

  assign busy     = (state_q != MD_IDLE);
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: behavioural multiplier/divider models, a directed vector
// table, hand-written flush/reset sequences and randomized ops.
module tb_md_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DATA_W  = 32;
  localparam int DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        ex_hold = 1'b0;
  logic        flush = 1'b0;
  logic        stallreq, busy, mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result = '0;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_opdata1, div_opdata2;
  logic [63:0] div_result = '0;
  logic        div_ready = 1'b0;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int dcnt     = 0;

  md_ctrl #(.MUL_LAT(MUL_LAT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .ex_hold(ex_hold), .flush(flush),
    .stallreq(stallreq), .busy(busy), .mul_signed(mul_signed),
    .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_result(div_result), .div_ready(div_ready),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  // Multiplier model: one register stage, so the product of operands first
  // presented in cycle t is visible in cycle t+MUL_LAT-1 and captured MUL_LAT edges later.
  always @(posedge clk) begin
    if (mul_signed)
      mul_result <= 64'(longint'($signed(mul_ina)) * longint'($signed(mul_inb)));
    else
      mul_result <= {32'b0, mul_ina} * {32'b0, mul_inb};
  end

  // Divider model: ready pulses the cycle after the DIV_CYC-th start cycle.
  always @(posedge clk) begin
    if (rst || div_annul) begin
      dcnt      <= 0;
      div_ready <= 1'b0;
    end else if (div_ready) begin
      dcnt      <= 0;
      div_ready <= 1'b0;
    end else if (div_start) begin
      dcnt <= dcnt + 1;
      if (dcnt == DIV_CYC - 1) begin
        div_ready <= 1'b1;
        if (div_signed)
          div_result <= {$signed(div_opdata1) % $signed(div_opdata2),
                         $signed(div_opdata1) / $signed(div_opdata2)};
        else
          div_result <= {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
      end
    end
  end

  // Reference: {HI, LO} of an instruction from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_hilo(input logic [1:0] code, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (code == 2'b00) return 64'(sa * sb);
    if (code == 2'b01) return ua * ub;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (code == 2'b10) begin
      q = sa / sb;
      r = sa - q * sb;
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Reference stall cycles: accept cycle plus wait cycles; DONE never stalls.
  function automatic int ref_stalls(input logic [1:0] code, input logic [31:0] b);
    if (!code[1]) return MUL_LAT + 1;
    if (b == 32'h0) return 1;
    return DIV_CYC + 2;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clk);
    check({tag, "_ctl"}, 64'({stallreq, busy, mul_signed, div_start, div_annul,
                              div_signed, hi_we, lo_we}), 64'h0);
    check({tag, "_data"}, {mul_ina | mul_inb | div_opdata1 | div_opdata2,
                           hi_wdata | lo_wdata}, 64'h0);
    @(posedge clk); #1;
  endtask

  // Runs one instruction from IDLE to the cycle after it leaves EX.
  task automatic run_op(input string name, input logic [1:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int stalls, starts, cycles, writes, hstall, exp_st;
    logic [31:0] got_hi, got_lo;
    logic dsig, we_ok, done;
    stalls = 0; starts = 0; cycles = 0; writes = 0; hstall = 0;
    got_hi = '0; got_lo = '0; dsig = 1'b0; we_ok = 1'b1; done = 1'b0;
    exp_st = ref_stalls(code, b);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; ex_hold = (hold > 0);
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (stallreq) stalls++;
      if (div_start) begin
        starts++;
        dsig = div_signed;
      end
      if (hi_we !== lo_we) we_ok = 1'b0;
      if (hi_we) begin
        writes++;
        got_hi = hi_wdata;
        got_lo = lo_wdata;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      for (int i = 0; i <= hold; i++) begin
        ex_hold = (i < hold);
        @(negedge clk);
        if (hi_we) writes++;
        if (stallreq) hstall++;
        if (div_start) starts++;
        @(posedge clk); #1;
      end
      check({name, "_hold_stall"}, 64'(hstall), 64'h0);
    end
    op_valid = 1'b0; ex_hold = 1'b0;
    @(negedge clk);
    check({name, "_tail_idle"}, 64'({busy, hi_we}), 64'h0);
    @(posedge clk); #1;
    check({name, "_done"}, 64'(done), 64'h1);
    check({name, "_hilo"}, {got_hi, got_lo}, {exp_hi, exp_lo});
    check({name, "_stalls"}, 64'(stalls), 64'(exp_st));
    check({name, "_occupancy"}, 64'(cycles), 64'(exp_st + 1));
    check({name, "_writes"}, 64'(writes), 64'h1);
    check({name, "_we_pair"}, 64'(we_ok), 64'h1);
    check({name, "_starts"}, 64'(starts), 64'((code[1] && b != 0) ? DIV_CYC : 0));
    if (code[1] && b != 0) check({name, "_div_signed"}, 64'(dsig), 64'(code == 2'b10));
    $display("op %s code=%0d a=%h b=%h hold=%0d -> hi=%h lo=%h stalls=%0d cycles=%0d",
             name, code, a, b, hold, got_hi, got_lo, stalls, cycles);
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  initial begin
    vec_t        vecs [9];
    logic [1:0]  rc;
    logic [31:0] ra, rb;
    logic [63:0] rr;
    int          rh, cnt_we, cnt_rdy, cnt_ann;

    vecs[0] = '{code: 2'b00, a: 32'd3,          b: 32'hFFFF_FFFC, hold: 0, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF4};
    vecs[1] = '{code: 2'b11, a: 32'd100,        b: 32'd7,         hold: 0, hi: 32'd2,         lo: 32'd14};
    vecs[2] = '{code: 2'b10, a: 32'hFFFF_FFF9, b: 32'd2,         hold: 0, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    vecs[3] = '{code: 2'b10, a: 32'd5,          b: 32'd0,         hold: 0, hi: 32'd5,         lo: 32'hFFFF_FFFF};
    vecs[4] = '{code: 2'b01, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hold: 3, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
    vecs[5] = '{code: 2'b00, a: 32'd7,          b: 32'd9,         hold: 0, hi: 32'd0,         lo: 32'd63};
    vecs[6] = '{code: 2'b11, a: 32'd5,          b: 32'd0,         hold: 1, hi: 32'd5,         lo: 32'hFFFF_FFFF};
    vecs[7] = '{code: 2'b10, a: 32'd7,          b: 32'hFFFF_FFFE, hold: 0, hi: 32'd1,         lo: 32'hFFFF_FFFD};
    vecs[8] = '{code: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hold: 0, hi: 32'd0,         lo: 32'd1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero_outputs("reset");

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].hold,
             vecs[i].hi, vecs[i].lo);

    // Flush ten cycles into a DIV: one annul pulse, no write, divider stays quiet.
    op_valid = 1'b1; op_code = 2'b10; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    check("flush_div_annul", 64'({div_annul, div_start, hi_we}), 64'b100);
    @(posedge clk); #1;
    flush = 1'b0;
    cnt_we = 0; cnt_rdy = 0; cnt_ann = 0;
    @(negedge clk);
    check("flush_div_idle", 64'(busy), 64'h0);
    repeat (40) begin
      if (hi_we) cnt_we++;
      if (div_ready) cnt_rdy++;
      if (div_annul) cnt_ann++;
      @(negedge clk);
    end
    check("flush_div_no_write", 64'(cnt_we), 64'h0);
    check("flush_div_no_ready", 64'(cnt_rdy), 64'h0);
    check("flush_div_single_annul", 64'(cnt_ann), 64'h0);
    @(posedge clk); #1;
    $display("op flush_div annulled after 10 cycles");

    // Reset in the middle of MUL_WAIT.
    op_valid = 1'b1; op_code = 2'b00; op_a = 32'd5; op_b = 32'd6;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_mul_busy", 64'({busy, mul_ina}), {31'b0, 1'b1, 32'd5});
    @(posedge clk); #1;
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero_outputs("rst_mid_mul");
    $display("op rst_mid_mul reset during MUL_WAIT");

    // Flush landing on the DONE cycle of a divide-by-zero.
    op_valid = 1'b1; op_code = 2'b11; op_a = 32'd5; op_b = 32'd0;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    check("flush_done_we", 64'({hi_we, lo_we}), 64'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_done_after", 64'({busy, hi_we}), 64'h0);
    @(posedge clk); #1;
    $display("op flush_done write suppressed");

    // op_valid with flush in IDLE is not accepted.
    op_valid = 1'b1; flush = 1'b1; op_code = 2'b00; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    check("flush_idle_stall", 64'(stallreq), 64'h0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    $display("op flush_idle not accepted");

    for (int i = 0; i < 30; i++) begin
      rc = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      if (rc == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      rh = $urandom_range(0, 2);
      rr = ref_hilo(rc, ra, rb);
      run_op($sformatf("rnd%0d", i), rc, ra, rb, rh, rr[63:32], rr[31:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
